// File: rtl/shift_readout_buffer.sv
// Double-buffered parallel-in / serial-out word bank with valid/ready readout.
// A staging bank lets the next frame be captured while the current one shifts out.
module shift_readout_buffer #(
    parameter int BITS   = 4,
    parameter int LENGTH = 4,
    localparam int CNT_W = $clog2(LENGTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load,
    input  logic [BITS*LENGTH-1:0]   data_in,
    output logic                     load_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITS-1:0]          data_out,
    output logic                     out_last,
    output logic                     overflow
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LENGTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [BITS-1:0]  r_shift [LENGTH];
    logic [BITS-1:0]  r_stage [LENGTH];
    logic [CNT_W-1:0] r_remaining;
    logic             r_staged;
    logic             r_overflow;

    logic [BITS-1:0]  w_in_word [LENGTH];
    logic [BITS-1:0]  w_shifted [LENGTH];
    logic             w_pop;
    logic             w_final_pop;
    logic             w_shift_free;
    logic             w_accept;
    logic             w_direct;
    logic             w_advance;

    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_word
        assign w_in_word[gi] = data_in[gi*BITS +: BITS];
        if (gi == LENGTH - 1) begin : g_top
            assign w_shifted[gi] = '0;
        end else begin : g_mid
            assign w_shifted[gi] = r_shift[gi+1];
        end
    end

    assign out_valid    = (r_remaining != '0);
    assign out_last     = (r_remaining == ONE_CNT);
    assign data_out     = out_valid ? r_shift[0] : '0;
    assign overflow     = r_overflow;

    assign w_pop        = out_valid & out_ready;
    assign w_final_pop  = w_pop & (r_remaining == ONE_CNT);
    assign w_shift_free = (r_remaining == '0) | w_final_pop;
    assign load_ready   = ~r_staged | w_final_pop;
    assign w_accept     = load & load_ready;
    // A staged frame always has precedence over a fresh load for the shift bank.
    assign w_advance    = w_shift_free & r_staged;
    assign w_direct     = w_shift_free & w_accept & ~r_staged;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LENGTH; i++) begin
                r_shift[i] <= '0;
                r_stage[i] <= '0;
            end
            r_remaining <= '0;
            r_staged    <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < LENGTH; i++) begin
                r_shift[i] <= '0;
                r_stage[i] <= '0;
            end
            r_remaining <= '0;
            r_staged    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_advance) begin
                r_shift     <= r_stage;
                r_remaining <= FULL_CNT;
            end else if (w_direct) begin
                r_shift     <= w_in_word;
                r_remaining <= FULL_CNT;
            end else if (w_pop) begin
                r_shift     <= w_shifted;
                r_remaining <= r_remaining - ONE_CNT;
            end

            if (w_accept && !w_direct) begin
                r_stage  <= w_in_word;
                r_staged <= 1'b1;
            end else if (w_advance) begin
                r_staged <= 1'b0;
            end

            if (load && !load_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
